// File: rtl/ram_march_tester.sv
// ram_march_tester: writes seed+addr to every RAM address, reads back and checks, reporting errors.
// Optional RAM_MARCH_INV_PASS_EN adds a second pass with the inverted pattern.
module ram_march_tester #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] seed,
    output logic                  en,
    output logic                  wr_rd,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] data_in,
    input  logic [DATA_WIDTH-1:0] data_out,
    input  logic                  out_en,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ADDR_WIDTH+1:0] err_count,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic                  timeout_flag
);
`ifdef RAM_MARCH_INV_PASS_EN
    localparam bit INV_PASS = 1'b1;
`else
    localparam bit INV_PASS = 1'b0;
`endif
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [WW-1:0] TMAX = WW'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, WRITE, READ, GAP, DONE} state_t;

    state_t                  state;
    logic [DATA_WIDTH-1:0]   seed_q;
    logic                    inv;
    logic [WW-1:0]           wait_cnt;
    logic [ADDR_WIDTH-1:0]   addr_nxt;
    logic [DATA_WIDTH-1:0]   exp_data;

    function automatic logic [DATA_WIDTH-1:0] pattern(input logic [DATA_WIDTH-1:0] s,
                                                      input logic [ADDR_WIDTH-1:0] a,
                                                      input logic i);
        return (s + DATA_WIDTH'(a)) ^ {DATA_WIDTH{i}};
    endfunction

    assign addr_nxt = addr + ADDR_WIDTH'(1);
    assign exp_data = pattern(seed_q, addr, inv);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            en           <= 1'b0;
            wr_rd        <= 1'b0;
            addr         <= '0;
            data_in      <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            err_count    <= '0;
            fail_addr    <= '0;
            timeout_flag <= 1'b0;
            seed_q       <= '0;
            inv          <= 1'b0;
            wait_cnt     <= '0;
        end else begin
            case (state)
                IDLE, DONE: if (start) begin
                    state        <= WRITE;
                    seed_q       <= seed;
                    inv          <= 1'b0;
                    err_count    <= '0;
                    fail_addr    <= '0;
                    timeout_flag <= 1'b0;
                    done         <= 1'b0;
                    pass         <= 1'b0;
                    busy         <= 1'b1;
                    en           <= 1'b1;
                    wr_rd        <= 1'b1;
                    addr         <= '0;
                    data_in      <= seed;
                end
                WRITE: if (addr == LAST) begin
                    state    <= READ;
                    wr_rd    <= 1'b0;
                    addr     <= '0;
                    wait_cnt <= '0;
                end else begin
                    addr    <= addr_nxt;
                    data_in <= pattern(seed_q, addr_nxt, inv);
                end
                READ: if (out_en || wait_cnt == TMAX) begin
                    state <= GAP;
                    en    <= 1'b0;
                    // out_en wins over a coincident timeout
                    if (!out_en || data_out != exp_data) begin
                        err_count <= (&err_count) ? err_count : err_count + (ADDR_WIDTH+2)'(1);
                        if (err_count == '0)
                            fail_addr <= addr;
                    end
                    if (!out_en)
                        timeout_flag <= 1'b1;
                end else begin
                    wait_cnt <= wait_cnt + WW'(1);
                end
                GAP: if (addr != LAST) begin
                    state    <= READ;
                    en       <= 1'b1;
                    addr     <= addr_nxt;
                    wait_cnt <= '0;
                end else if (INV_PASS && !inv) begin
                    state   <= WRITE;
                    inv     <= 1'b1;
                    en      <= 1'b1;
                    wr_rd   <= 1'b1;
                    addr    <= '0;
                    data_in <= ~seed_q;
                end else begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    pass  <= (err_count == '0);
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ram_march_tester.sv
// tb_ram_march_tester: scoreboard bench with a behavioural RAM model and a reference result model.
module tb_ram_march_tester;
    localparam int AW = 4, DW = 8, DEPTH = 16, TIMEOUT = 15;
`ifdef RAM_MARCH_INV_PASS_EN
    localparam int PASSES = 2;
`else
    localparam int PASSES = 1;
`endif

    logic          clk = 1'b0, reset = 1'b1, start = 1'b0;
    logic [DW-1:0] seed = '0;
    logic          en, wr_rd, out_en = 1'b0;
    logic [AW-1:0] addr, fail_addr;
    logic [DW-1:0] data_in, data_out = '0;
    logic          busy, done, pass, timeout_flag;
    logic [AW+1:0] err_count;

    ram_march_tester #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .start(start), .seed(seed), .en(en), .wr_rd(wr_rd),
        .addr(addr), .data_in(data_in), .data_out(data_out), .out_en(out_en), .busy(busy),
        .done(done), .pass(pass), .err_count(err_count), .fail_addr(fail_addr),
        .timeout_flag(timeout_flag)
    );

    always #5 clk = ~clk;

    typedef struct {int cycles; int errs; int fa; int pass; int tf; int rl;} res_t;
    res_t            res_q[$];
    logic [AW+DW-1:0] wq[$];
    int passed = 0, total = 0;
    int mode = 0;  // 0 ideal, 1 data_out[0] stuck-0, 2 never responds, 3 data_out[7] stuck-0
    logic [DW-1:0] mem [DEPTH];

    always @(posedge clk) begin
        if (en && wr_rd) mem[addr] <= data_in;
        out_en   <= en && !wr_rd && mode != 2;
        data_out <= !(en && !wr_rd) ? '0 :
                    mode == 1 ? mem[addr] & 8'hFE :
                    mode == 3 ? mem[addr] & 8'h7F : mem[addr];
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    int   bc = 0, rl = 0;
    logic done_q = 1'b0;
    always @(negedge clk) begin
        if (en && wr_rd) begin
            logic [AW+DW-1:0] w;
            if (wq.size() == 0) check("unexpected_write", 1, 0);
            else begin
                w = wq.pop_front();
                check("write_addr", int'(addr), int'(w[AW+DW-1:DW]));
                check("write_data", int'(data_in), int'(w[DW-1:0]));
            end
        end
        if (en && !wr_rd) rl++;
        else begin
            if (rl != 0 && res_q.size() != 0) check("read_len", rl, res_q[0].rl);
            rl = 0;
        end
        if (busy) bc++;
        else begin
            if (done && !done_q) begin
                res_t r;
                if (res_q.size() == 0) check("unexpected_done", 1, 0);
                else begin
                    r = res_q.pop_front();
                    check("run_cycles", bc + 1, r.cycles);
                    check("err_count", int'(err_count), r.errs);
                    check("fail_addr", int'(fail_addr), r.fa);
                    check("pass", int'(pass), r.pass);
                    check("timeout_flag", int'(timeout_flag), r.tf);
                end
            end
            bc = 0;
        end
        done_q = done;
    end

    task automatic pulse_start(input logic [DW-1:0] s);
        @(negedge clk);
        seed  = s;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seed  = DW'($urandom);
    endtask

    task automatic push_writes(input logic [DW-1:0] s, input int passes);
        for (int p = 0; p < passes; p++)
            for (int a = 0; a < DEPTH; a++)
                wq.push_back({AW'(a), DW'(((int'(s) + a) & 255) ^ (p != 0 ? 255 : 0))});
    endtask

    task automatic run_test(input logic [DW-1:0] s, input int m, input bit restart_mid);
        res_t r;
        int e, got, n;
        r = '{default: 0};
        mode = m;
        for (int p = 0; p < PASSES; p++)
            for (int a = 0; a < DEPTH; a++) begin
                e   = ((int'(s) + a) & 255) ^ (p != 0 ? 255 : 0);
                got = m == 1 ? (e & 254) : m == 3 ? (e & 127) : e;
                if (m == 2 || got != e) begin
                    if (r.errs == 0) r.fa = a;
                    r.errs++;
                end
                if (m == 2) r.tf = 1;
            end
        if (r.errs > 63) r.errs = 63;
        r.pass   = (r.errs == 0);
        r.rl     = m == 2 ? TIMEOUT : 2;
        r.cycles = 1 + PASSES * (DEPTH + DEPTH * (r.rl + 1));
        push_writes(s, PASSES);
        res_q.push_back(r);
        pulse_start(s);
        if (restart_mid) begin
            repeat (4) @(negedge clk);
            pulse_start(DW'($urandom));
        end
        n = 0;
        while (!done && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            check("done_reached", 0, 1);
            wq.delete();
            res_q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        check("rst_en", int'(en), 0);
        check("rst_wr_rd", int'(wr_rd), 0);
        check("rst_addr", int'(addr), 0);
        check("rst_data_in", int'(data_in), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_pass", int'(pass), 0);
        check("rst_err_count", int'(err_count), 0);
        check("rst_fail_addr", int'(fail_addr), 0);
        check("rst_timeout_flag", int'(timeout_flag), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        run_test(8'h00, 0, 1'b0);
        run_test(8'h00, 1, 1'b0);
        run_test(8'h00, 2, 1'b0);
        run_test(8'hF8, 0, 1'b0);
        run_test(8'h3C, 0, 1'b1);
        run_test(8'h00, 3, 1'b0);

        // abort during the read phase after an error has been counted
        mode = 1;
        push_writes(8'h00, 1);
        pulse_start(8'h00);
        n = 0;
        while (!(en && !wr_rd) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("abort_reached_read", int'(en && !wr_rd), 1);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_en", int'(en), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_err_count", int'(err_count), 0);
        repeat (3) @(negedge clk);
        check("abort_still_idle", int'(en), 0);

        run_test(8'h00, 0, 1'b0);
        for (int i = 0; i < 6; i++) run_test(DW'($urandom), int'($urandom_range(0, 3)), 1'b0);

        check("write_queue_empty", wq.size(), 0);
        check("result_queue_empty", res_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/ram_march_tester.md
# ram_march_tester

Self-checking initiator for the team's single-port RAM. It drives the RAM's request side (`en`, `wr_rd`, `addr`, `data_in`) and consumes its response side (`data_out`, `out_en`). On `start` it writes a seed-derived pattern to every address, then reads each address back and compares it. It sits between the RAM and the system status logic and reports pass/fail, the error count and the first failing address.

## Interface
- `ADDR_WIDTH`, 4: RAM address width.
- `DATA_WIDTH`, 8: RAM data width.
- `DEPTH`, 16: number of addresses tested, 0..DEPTH-1; must equal 2**ADDR_WIDTH.
- `TIMEOUT`, 15: maximum cycles to wait for `out_en` per read.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  begin test; sampled only in IDLE.
- `seed`  in  DATA_WIDTH  pattern base; captured when `start` is accepted.
- `en`  out  1  RAM enable.
- `wr_rd`  out  1  RAM direction: 1 = write, 0 = read.
- `addr`  out  ADDR_WIDTH  RAM address.
- `data_in`  out  DATA_WIDTH  RAM write data.
- `data_out`  in  DATA_WIDTH  RAM read data.
- `out_en`  in  1  RAM read-data valid.
- `busy`  out  1  test in progress.
- `done`  out  1  test finished; held until the next accepted `start` or `reset`.
- `pass`  out  1  valid when `done`; 1 iff `err_count` == 0.
- `err_count`  out  ADDR_WIDTH+2  mismatches plus timeouts; saturates at all-ones.
- `fail_addr`  out  ADDR_WIDTH  address of the first error; 0 if none.
- `timeout_flag`  out  1  at least one read timed out.

## Operation
- Expected data for address a is E(a) = `seed` + a, truncated to DATA_WIDTH bits (mod 2**DATA_WIDTH).
- States: IDLE, WRITE, READ, GAP, DONE.
- **IDLE**
  - Outputs `en`=0 and `busy`=0.
  - On `start`=1: capture `seed`; clear `err_count`, `fail_addr`, `timeout_flag`, `done` and `pass`; set `busy`=1; go to WRITE with `addr`=0.
- **WRITE**
  - Drives `en`=1, `wr_rd`=1, `data_in`=E(`addr`), for one cycle per address.
  - After `addr`=DEPTH-1, go to READ with `addr`=0.
- **READ**
  - Drives `en`=1, `wr_rd`=0, holds `addr`, and increments a wait counter every cycle.
  - If `out_en`=1: compare `data_out` with E(`addr`); on mismatch increment `err_count`; go to GAP.
  - Else if the wait counter reaches TIMEOUT: count one error, set `timeout_flag`; go to GAP.
  - The first error of any kind loads `fail_addr`.
- **GAP**
  - One cycle with `en`=0; `out_en` is ignored.
  - Then advance to the next address in READ, or to DONE after DEPTH-1.
- **DONE**
  - `busy`=0, `done`=1, `pass`=(`err_count`==0), `en`=0.
  - Accepts a new `start`, which behaves as it does from IDLE.
- `start` while `busy` is ignored.
- `reset` mid-test aborts immediately: the next cycle is IDLE with all outputs at their reset values, and no further RAM requests are issued.

## Timing
- Reset value of every output is 0.
- `start` sampled at edge N: first write request (`en`=1, `addr`=0) is visible after edge N.
- Write phase: exactly DEPTH cycles.
- Read phase, per address: (cycles until `out_en`) + 1 GAP cycle.
- With a RAM model that asserts `out_en` one cycle after sampling a read request, each read takes 3 cycles. A full run is then 1 + 16 + 48 = 65 cycles from `start` to `done`=1.
- Timed-out read: TIMEOUT READ cycles + 1 GAP cycle.
- `out_en` and the timeout condition in the same cycle: treated as `out_en`; the compare result decides, and no timeout is counted.
- Address counter wraps only on phase transitions; it never exceeds DEPTH-1.

## Configuration
- `RAM_MARCH_INV_PASS_EN`
  - Defined: after the first read phase, run a second WRITE/READ/GAP pass using the inverted pattern ~E(a) before DONE. Errors from both passes accumulate in `err_count`, so the maximum count is 2*DEPTH. `fail_addr` still records the first error overall. Ideal-model run length: 129 cycles.
  - Undefined: a single pass only.

## Test plan
- Ideal RAM model (1-cycle `out_en`), `seed`=8'h00, `start` pulse -> `done`=1 65 cycles later; `pass`=1, `err_count`=0, `timeout_flag`=0; write data 0x00..0x0F in order.
- Model forcing `data_out`[0]=0, `seed`=8'h00 -> `err_count`=8, `fail_addr`=1, `pass`=0.
- Model that never asserts `out_en` -> 16 timeouts, `err_count`=16, `timeout_flag`=1, `fail_addr`=0; each read lasts 15 cycles of `en`=1.
- `seed`=8'hF8 -> address 8 expects 8'h00 (wrap-around); with the ideal model `pass`=1.
- `start` pulsed again mid-write -> ignored, sequence unchanged. Then `reset` asserted during the read phase -> next cycle `en`=0, `busy`=0, `done`=0, `err_count`=0. Then a fresh `start` -> normal pass.
- With `RAM_MARCH_INV_PASS_EN` and a `data_out`[7] stuck-at-0 model, `seed`=8'h00 -> first pass clean, inverted pass fails all 16 addresses: `err_count`=16, `fail_addr`=0.
